// File: rtl/nec_ir_decoder_pkg.sv
// Shared definitions for the NEC IR receiver: FSM states, nominal phase
// lengths in ticks (one tick = T/8 = 70.3125 us) and window/divider helpers.
package nec_ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        CHECK,
        RPT_MARK
    } necState_t;

    localparam int NOM_LEAD_MARK  = 128;
    localparam int NOM_LEAD_SPACE = 64;
    localparam int NOM_RPT_SPACE  = 32;
    localparam int NOM_BIT_MARK   = 8;
    localparam int NOM_ZERO_SPACE = 8;
    localparam int NOM_ONE_SPACE  = 24;

    // Lower edge of the acceptance window around a nominal duration.
    function automatic int winLo(input int nom, input int tolPct);
        return nom * (100 - tolPct) / 100;
    endfunction

    // Upper edge of the acceptance window around a nominal duration.
    function automatic int winHi(input int nom, input int tolPct);
        return nom * (100 + tolPct) / 100;
    endfunction

    // Clocks per tick: CLOCK_HZ * 70.3125 us = CLOCK_HZ * 9 / 128000.
    function automatic int tickDiv(input int clockHz);
        return int'(longint'(clockHz) * 64'sd9 / 64'sd128000);
    endfunction

endpackage

// File: rtl/nec_ir_decoder_if.sv
// Result bus of the NEC decoder toward the command path.
interface nec_ir_decoder_if;
    logic        validOUT;
    logic        repeatOUT;
    logic [15:0] addrOUT;
    logic [7:0]  cmdOUT;
    logic        errorOUT;

    modport master (
        output validOUT,
        output repeatOUT,
        output addrOUT,
        output cmdOUT,
        output errorOUT
    );

    modport slave (
        input validOUT,
        input repeatOUT,
        input addrOUT,
        input cmdOUT,
        input errorOUT
    );
endinterface

// File: rtl/nec_ir_decoder_tick_gen.sv
// Restartable tick divider: one-cycle tick every TICK_DIV clocks, phase
// realigned to zero whenever restart is high (restart suppresses the tick).
module nec_tick_gen #(
    parameter int TICK_DIV = 703125
) (
    input  logic clkIN,
    input  logic resetIN,
    input  logic restart,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] divCnt;

    // Divider counter, wraps at TICK_DIV and restarts on every line edge.
    always_ff @(posedge clkIN) begin
        if (resetIN || restart) begin
            divCnt <= '0;
        end else if (divCnt == LAST) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign tick = (divCnt == LAST) && !restart;

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR decoder: measures mark/space durations in ticks, decodes full
// frames and repeat codes, and reports them on the result bus.
// Build option: define NEC_EXTENDED_ADDR_EN for 16-bit addresses
// ({A1, A0}, no A1 == ~A0 check); otherwise addrOUT = {8'h00, A0}.
module nec_ir_decoder
    import nec_ir_pkg::*;
#(
    parameter int CLOCK_HZ      = 50_000_000,
    parameter int TOL_PCT       = 25,
    parameter int RX_ACTIVE_LOW = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int DISARM_TICKS  = 1707
) (
    input  logic             clkIN,
    input  logic             resetIN,
    input  logic             rxIN,
    nec_ir_decoder_if.master resultBus
);
    localparam int TICK_DIV = tickDiv(CLOCK_HZ);

    localparam logic [7:0] LM_LO = 8'(winLo(NOM_LEAD_MARK, TOL_PCT));
    localparam logic [7:0] LM_HI = 8'(winHi(NOM_LEAD_MARK, TOL_PCT));
    localparam logic [7:0] LS_LO = 8'(winLo(NOM_LEAD_SPACE, TOL_PCT));
    localparam logic [7:0] LS_HI = 8'(winHi(NOM_LEAD_SPACE, TOL_PCT));
    localparam logic [7:0] RS_LO = 8'(winLo(NOM_RPT_SPACE, TOL_PCT));
    localparam logic [7:0] RS_HI = 8'(winHi(NOM_RPT_SPACE, TOL_PCT));
    localparam logic [7:0] BM_LO = 8'(winLo(NOM_BIT_MARK, TOL_PCT));
    localparam logic [7:0] BM_HI = 8'(winHi(NOM_BIT_MARK, TOL_PCT));
    localparam logic [7:0] ZS_LO = 8'(winLo(NOM_ZERO_SPACE, TOL_PCT));
    localparam logic [7:0] ZS_HI = 8'(winHi(NOM_ZERO_SPACE, TOL_PCT));
    localparam logic [7:0] OS_LO = 8'(winLo(NOM_ONE_SPACE, TOL_PCT));
    localparam logic [7:0] OS_HI = 8'(winHi(NOM_ONE_SPACE, TOL_PCT));

    // Leader space and bit space accept two windows; time out past the wider.
    localparam logic [7:0] LS_TIMEOUT = (LS_HI > RS_HI) ? LS_HI : RS_HI;
    localparam logic [7:0] BS_TIMEOUT = (OS_HI > ZS_HI) ? OS_HI : ZS_HI;

    localparam logic [10:0] DISARM_LIM = 11'(DISARM_TICKS);
    localparam logic        IDLE_LEVEL = (RX_ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   markNow;
    logic                   markPrev;
    logic                   edgeSeen;
    logic                   markStart;
    logic                   markEnd;
    logic                   tick;
    logic [7:0]             dur;
    logic [10:0]            idleCnt;
    logic                   armed;
    necState_t              state;
    necState_t              stateNext;
    logic [5:0]             bitCnt;
    logic [31:0]            shiftReg;
    logic                   clrBits;
    logic                   shiftEn;
    logic                   shiftBit;
    logic                   doValid;
    logic                   doRepeat;
    logic                   doError;
    logic                   cmdOk;
    logic                   addrOk;
    logic [15:0]            frameAddr;
    logic                   validReg;
    logic                   repeatReg;
    logic                   errorReg;
    logic [15:0]            addrReg;
    logic [7:0]             cmdReg;

    function automatic logic inWin(input logic [7:0] d, input logic [7:0] lo,
                                   input logic [7:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // Synchroniser, cleared to the idle line level so reset creates no edge.
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            syncReg  <= {SYNC_STAGES{IDLE_LEVEL}};
            markPrev <= 1'b0;
        end else begin
            syncReg  <= {syncReg[SYNC_STAGES-2:0], rxIN};
            markPrev <= markNow;
        end
    end

    assign markNow   = syncReg[SYNC_STAGES-1] ^ IDLE_LEVEL;
    assign edgeSeen  = markNow ^ markPrev;
    assign markStart = edgeSeen & markNow;
    assign markEnd   = edgeSeen & ~markNow;

    nec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) tickGen (
        .clkIN   (clkIN),
        .resetIN (resetIN),
        .restart (edgeSeen),
        .tick    (tick)
    );

    // Phase duration and idle counters; an edge clears both and beats a tick.
    always_ff @(posedge clkIN) begin
        if (resetIN || edgeSeen) begin
            dur     <= '0;
            idleCnt <= '0;
        end else if (tick) begin
            if (dur != 8'hFF) begin
                dur <= dur + 8'd1;
            end
            if (idleCnt != DISARM_LIM) begin
                idleCnt <= idleCnt + 11'd1;
            end
        end
    end

    // Repeat acceptance: armed by a good frame, dropped by errors or long idle.
    always_ff @(posedge clkIN) begin
        if (resetIN || doError || idleCnt == DISARM_LIM) begin
            armed <= 1'b0;
        end else if (doValid && !doRepeat) begin
            armed <= 1'b1;
        end
    end

    assign cmdOk = (shiftReg[31:24] == ~shiftReg[23:16]);
`ifdef NEC_EXTENDED_ADDR_EN
    assign addrOk    = 1'b1;
    assign frameAddr = shiftReg[15:0];
`else
    assign addrOk    = (shiftReg[15:8] == ~shiftReg[7:0]);
    assign frameAddr = {8'h00, shiftReg[7:0]};
`endif

    // FSM state register.
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state and per-cycle actions; timeouts take priority over edges.
    always_comb begin
        stateNext = state;
        clrBits   = 1'b0;
        shiftEn   = 1'b0;
        shiftBit  = 1'b0;
        doValid   = 1'b0;
        doRepeat  = 1'b0;
        doError   = 1'b0;
        unique case (state)
            IDLE: begin
                if (markStart) stateNext = LEAD_MARK;
            end
            LEAD_MARK: begin
                if (dur > LM_HI) doError = 1'b1;
                else if (markEnd) stateNext = inWin(dur, LM_LO, LM_HI) ? LEAD_SPACE : IDLE;
            end
            LEAD_SPACE: begin
                if (dur > LS_TIMEOUT) begin
                    doError = 1'b1;
                end else if (markStart) begin
                    if (inWin(dur, LS_LO, LS_HI)) begin
                        stateNext = BIT_MARK;
                        clrBits   = 1'b1;
                    end else if (inWin(dur, RS_LO, RS_HI)) begin
                        stateNext = RPT_MARK;
                    end else begin
                        doError = 1'b1;
                    end
                end
            end
            BIT_MARK: begin
                if (dur > BM_HI) doError = 1'b1;
                else if (markEnd) begin
                    if (inWin(dur, BM_LO, BM_HI)) stateNext = BIT_SPACE;
                    else doError = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (dur > BS_TIMEOUT) begin
                    doError = 1'b1;
                end else if (markStart) begin
                    if (inWin(dur, ZS_LO, ZS_HI)) begin
                        shiftEn = 1'b1;
                    end else if (inWin(dur, OS_LO, OS_HI)) begin
                        shiftEn  = 1'b1;
                        shiftBit = 1'b1;
                    end else begin
                        doError = 1'b1;
                    end
                    if (shiftEn) stateNext = (bitCnt == 6'd31) ? CHECK : BIT_MARK;
                end
            end
            CHECK: begin
                stateNext = IDLE;
                if (cmdOk && addrOk) doValid = 1'b1;
                else doError = 1'b1;
            end
            RPT_MARK: begin
                if (dur > BM_HI) begin
                    doError = 1'b1;
                end else if (markEnd) begin
                    if (inWin(dur, BM_LO, BM_HI) && armed) begin
                        doValid   = 1'b1;
                        doRepeat  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        doError = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        if (doError) stateNext = IDLE;
    end

    // Bit counter and LSB-first shift register (new bit enters at bit 31).
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            bitCnt   <= '0;
            shiftReg <= '0;
        end else if (clrBits) begin
            bitCnt <= '0;
        end else if (shiftEn) begin
            bitCnt   <= bitCnt + 6'd1;
            shiftReg <= {shiftBit, shiftReg[31:1]};
        end
    end

    // Registered result strobes; address/command change only on a new frame.
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            validReg  <= 1'b0;
            repeatReg <= 1'b0;
            errorReg  <= 1'b0;
            addrReg   <= '0;
            cmdReg    <= '0;
        end else begin
            validReg  <= doValid;
            repeatReg <= doValid & doRepeat;
            errorReg  <= doError;
            if (doValid && !doRepeat) begin
                addrReg <= frameAddr;
                cmdReg  <= shiftReg[23:16];
            end
        end
    end

    assign resultBus.validOUT  = validReg;
    assign resultBus.repeatOUT = repeatReg;
    assign resultBus.errorOUT  = errorReg;
    assign resultBus.addrOUT   = addrReg;
    assign resultBus.cmdOUT    = cmdReg;

endmodule
